// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel APB timer: register word offsets,
// CTRL bit positions and the per-channel address stride.
package multi_timer_pkg;
  localparam logic [1:0] LOAD_OFS   = 2'd0;
  localparam logic [1:0] CTRL_OFS   = 2'd1;
  localparam logic [1:0] VALUE_OFS  = 2'd2;
  localparam logic [1:0] STATUS_OFS = 2'd3;

  localparam int EN_BIT  = 0;
  localparam int PER_BIT = 1;
  localparam int IE_BIT  = 2;

  localparam int CTRL_W    = 3;
  localparam int CH_STRIDE = 16;
endpackage

// File: rtl/timer_channel.sv
// One timer channel: LOAD/CTRL registers, up-counter and sticky pending flag.
// Expiry happens when the counter reaches LOAD-1, giving a period of LOAD cycles.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int                WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_LOAD = '0,
  parameter logic [CTRL_W-1:0] RESET_CTRL = '0
) (
  input  logic              pclk,
  input  logic              nreset,
  input  logic              load_we_i,
  input  logic              ctrl_we_i,
  input  logic              status_we_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [CTRL_W-1:0] ctrl_wdata_i,
  output logic [WIDTH-1:0]  load_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [WIDTH-1:0]  value_o,
  output logic              pending_o,
  output logic              expire_o
);
  logic [WIDTH-1:0]  load_q, load_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              pend_q, pend_d;
  logic              expire;

  // LOAD = 0 never expires, so the counter simply parks at 0.
  assign expire = ctrl_q[EN_BIT] && (load_q != '0) && (cnt_q == load_q - WIDTH'(1));

  always_comb begin
    load_d = load_q;
    ctrl_d = ctrl_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (ctrl_q[EN_BIT] && (load_q != '0)) begin
      cnt_d = expire ? '0 : cnt_q + WIDTH'(1);
    end
    if (expire && !ctrl_q[PER_BIT]) begin
      ctrl_d[EN_BIT] = 1'b0;
    end
    // A software CTRL write overrides the one-shot auto-disable.
    if (ctrl_we_i) begin
      ctrl_d = ctrl_wdata_i;
      if (!ctrl_wdata_i[EN_BIT]) begin
        cnt_d = expire ? '0 : cnt_q;
      end else if (!ctrl_q[EN_BIT]) begin
        cnt_d = '0;
      end
    end
    if (load_we_i) begin
      load_d = wdata_i;
      cnt_d  = '0;
    end
    if (status_we_i && wdata_i[0]) begin
      pend_d = 1'b0;
    end
    if (expire) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!nreset) begin
      load_q <= RESET_LOAD;
      ctrl_q <= RESET_CTRL;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      load_q <= load_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign load_o    = load_q;
  assign ctrl_o    = ctrl_q;
  assign value_o   = cnt_q;
  assign pending_o = pend_q;
  assign expire_o  = expire;
endmodule

// File: rtl/multi_timer_apb.sv
// APB3 front end for NUM_CH timer channels: address decode, read mux and the
// registered per-channel irq lines plus the combined fabint level.
module multi_timer_apb
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int WIDTH          = 32,
  parameter int DEFAULT_PERIOD = 10000000,
  parameter int CH0_AUTOSTART  = 1
) (
  input  logic              pclk,
  input  logic              nreset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] irq,
  output logic              fabint
);
  localparam int CH_LSB = $clog2(CH_STRIDE);
  localparam int CH_W   = 8 - CH_LSB;

  // Handshake: no wait states, so a transfer completes on every cycle where
  // psel & penable are high; writes commit on that edge, reads are sampled then.
  logic [CH_W-1:0] ch_sel;
  logic [1:0]      reg_sel;
  logic            access, ch_ok, wr_en, rd_en;

  assign ch_sel  = paddr[7:CH_LSB];
  assign reg_sel = paddr[CH_LSB-1:2];
  assign access  = psel && penable;
  assign ch_ok   = {1'b0, ch_sel} < (CH_W+1)'(NUM_CH);
  assign wr_en   = access && pwrite && ch_ok;
  assign rd_en   = access && !pwrite && ch_ok;
  assign pslverr = access && !ch_ok;
  assign pready  = 1'b1;

  logic [NUM_CH-1:0] load_we, ctrl_we, status_we, pending, ie, expire;
  logic [WIDTH-1:0]  load_v  [NUM_CH];
  logic [WIDTH-1:0]  value_v [NUM_CH];
  logic [CTRL_W-1:0] ctrl_v  [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CTRL_W-1:0] RST_CTRL =
      (i == 0 && CH0_AUTOSTART != 0) ? 3'b111 : 3'b000;
    logic sel;

    assign sel          = wr_en && (ch_sel == CH_W'(i));
    assign load_we[i]   = sel && (reg_sel == LOAD_OFS);
    assign ctrl_we[i]   = sel && (reg_sel == CTRL_OFS);
    assign status_we[i] = sel && (reg_sel == STATUS_OFS);
    assign ie[i]        = ctrl_v[i][IE_BIT];

    timer_channel #(
      .WIDTH      (WIDTH),
      .RESET_LOAD (WIDTH'(DEFAULT_PERIOD)),
      .RESET_CTRL (RST_CTRL)
    ) u_ch (
      .pclk         (pclk),
      .nreset       (nreset),
      .load_we_i    (load_we[i]),
      .ctrl_we_i    (ctrl_we[i]),
      .status_we_i  (status_we[i]),
      .wdata_i      (pwdata[WIDTH-1:0]),
      .ctrl_wdata_i (pwdata[CTRL_W-1:0]),
      .load_o       (load_v[i]),
      .ctrl_o       (ctrl_v[i]),
      .value_o      (value_v[i]),
      .pending_o    (pending[i]),
      .expire_o     (expire[i])
    );
  end

  always_comb begin
    prdata = '0;
    if (rd_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel == CH_W'(i)) begin
          case (reg_sel)
            LOAD_OFS:   prdata = 32'(load_v[i]);
            CTRL_OFS:   prdata = 32'(ctrl_v[i]);
            VALUE_OFS:  prdata = 32'(value_v[i]);
            STATUS_OFS: prdata = {31'd0, pending[i]};
            default:    prdata = '0;
          endcase
        end
      end
    end
  end

  // fabint is derived from pending & ie directly so it aligns with irq.
  logic [NUM_CH-1:0] irq_q;
  logic              fabint_q;

  always_ff @(posedge pclk) begin
    if (!nreset) begin
      irq_q    <= '0;
      fabint_q <= 1'b0;
    end else begin
      irq_q    <= pending & ie;
      fabint_q <= |(pending & ie);
    end
  end

  assign irq    = irq_q;
  assign fabint = fabint_q;

  logic unused_bits;
  assign unused_bits = ^{paddr[1:0], pwdata, expire};
endmodule

// File: tb/tb_multi_timer_apb.sv
// Directed bench for multi_timer_apb with a short DEFAULT_PERIOD so the
// autostarting channel 0 expires within a few dozen cycles.
module tb_multi_timer_apb;
  localparam int NUM_CH = 4;
  localparam int PERIOD = 20;

  logic              pclk = 1'b0;
  logic              nreset;
  logic              psel, penable, pwrite;
  logic [7:0]        paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready, pslverr;
  logic [NUM_CH-1:0] irq;
  logic              fabint;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] rd;
  logic        err;

  multi_timer_apb #(
    .NUM_CH(NUM_CH), .WIDTH(32), .DEFAULT_PERIOD(PERIOD), .CH0_AUTOSTART(1)
  ) dut (
    .pclk(pclk), .nreset(nreset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .irq(irq), .fabint(fabint)
  );

  always #5 pclk = ~pclk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    tick(); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick(); penable = 1'b1;
    tick(); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    tick(); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick(); penable = 1'b1;
    #1; d = prdata; e = pslverr;
    tick(); psel = 1'b0; penable = 1'b0;
  endtask

  // Holds a read access phase on the bus and samples the combinational prdata.
  task automatic peek_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1;
    check(tag, prdata, exp);
  endtask

  initial begin
    nreset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (3) tick();
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_fabint", 32'(fabint), 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    apb_read(8'h00, rd, err); check("rst_load0", rd, PERIOD);
    apb_read(8'h04, rd, err); check("rst_ctrl0", rd, 32'h7);
    apb_read(8'h14, rd, err); check("rst_ctrl1", rd, 32'h0);
    apb_read(8'h30, rd, err); check("rst_load3", rd, PERIOD);
    nreset = 1'b1;

    // Channel 0 autostart: expiry after PERIOD edges, fabint one edge later.
    repeat (PERIOD - 1) tick();
    peek_chk("ch0_pend_early", 8'h0C, 32'h0);
    check("ch0_fabint_early", 32'(fabint), 32'h0);
    tick();
    peek_chk("ch0_pend_set", 8'h0C, 32'h1);
    check("ch0_fabint_lag", 32'(fabint), 32'h0);
    tick();
    check("ch0_fabint", 32'(fabint), 32'h1);
    check("ch0_irq", 32'(irq), 32'h1);
    peek_chk("ch0_value", 8'h08, 32'h1);
    peek_chk("ch1_idle", 8'h18, 32'h0);
    peek_chk("ch3_idle", 8'h3C, 32'h0);
    apb_write(8'h0C, 32'h1);
    peek_chk("ch0_w1c", 8'h0C, 32'h0);
    check("ch0_fabint_hold", 32'(fabint), 32'h1);
    tick();
    check("ch0_fabint_drop", 32'(fabint), 32'h0);
    repeat (14) tick();
    peek_chk("ch0_pend_pre2", 8'h0C, 32'h0);
    tick();
    peek_chk("ch0_pend_2nd", 8'h0C, 32'h1);
    peek_chk("ch0_value_2nd", 8'h08, 32'h0);
    apb_write(8'h04, 32'h0);
    apb_write(8'h0C, 32'h1);
    tick();
    check("ch0_off_fabint", 32'(fabint), 32'h0);
    peek_chk("ch0_ctrl_off", 8'h04, 32'h0);

    // Channel 1 one-shot, LOAD = 5.
    apb_write(8'h10, 32'd5);
    apb_write(8'h14, 32'h5);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      peek_chk("ch1_value_seq", 8'h18, 32'(k));
    end
    tick();
    peek_chk("ch1_pend", 8'h1C, 32'h1);
    peek_chk("ch1_ctrl_en_clr", 8'h14, 32'h4);
    check("ch1_irq_lag", 32'(irq), 32'h0);
    tick();
    check("ch1_irq", 32'(irq), 32'h2);
    check("ch1_fabint", 32'(fabint), 32'h1);
    repeat (10) tick();
    peek_chk("ch1_value_hold", 8'h18, 32'h0);
    apb_write(8'h1C, 32'h1);
    tick();
    check("ch1_fabint_clr", 32'(fabint), 32'h0);
    repeat (8) tick();
    peek_chk("ch1_no_reexp", 8'h1C, 32'h0);

    // Channel 2 periodic, LOAD = 3, ie off then on.
    apb_write(8'h20, 32'd3);
    apb_write(8'h24, 32'h3);
    peek_chk("ch2_pend0", 8'h2C, 32'h0);
    tick(); tick();
    peek_chk("ch2_value2", 8'h28, 32'h2);
    tick();
    peek_chk("ch2_pend", 8'h2C, 32'h1);
    peek_chk("ch2_value_wrap", 8'h28, 32'h0);
    tick();
    check("ch2_irq_masked", 32'(irq), 32'h0);
    check("ch2_fabint_masked", 32'(fabint), 32'h0);
    tick(); tick();
    peek_chk("ch2_period", 8'h28, 32'h0);
    apb_write(8'h24, 32'h7);
    check("ch2_irq_lag", 32'(irq), 32'h0);
    tick();
    check("ch2_irq_ie", 32'(irq), 32'h4);
    apb_write(8'h24, 32'h0);
    apb_write(8'h2C, 32'h1);

    // Channel 3: W1C on the expiry edge loses, one later clears.
    apb_write(8'h30, 32'd4);
    apb_write(8'h34, 32'h5);
    tick();
    apb_write(8'h3C, 32'h1);
    peek_chk("ch3_set_wins", 8'h3C, 32'h1);
    peek_chk("ch3_oneshot", 8'h34, 32'h4);
    apb_write(8'h3C, 32'h1);
    peek_chk("ch3_w1c", 8'h3C, 32'h0);
    check("ch3_fabint_hold", 32'(fabint), 32'h1);
    tick();
    check("ch3_fabint_drop", 32'(fabint), 32'h0);

    // Channel 1: LOAD = 1 expires every cycle, then LOAD = 0 parks.
    apb_write(8'h10, 32'd1);
    apb_write(8'h14, 32'h3);
    peek_chk("l1_pend0", 8'h1C, 32'h0);
    tick();
    peek_chk("l1_pend", 8'h1C, 32'h1);
    apb_write(8'h1C, 32'h1);
    peek_chk("l1_set_wins", 8'h1C, 32'h1);
    apb_write(8'h10, 32'd0);
    apb_write(8'h1C, 32'h1);
    peek_chk("l0_clr", 8'h1C, 32'h0);
    repeat (5) tick();
    peek_chk("l0_no_exp", 8'h1C, 32'h0);
    peek_chk("l0_value", 8'h18, 32'h0);

    // Out-of-range channel and ignored low address bits.
    apb_read(8'h50, rd, err);
    check("oob_prdata", rd, 32'h0);
    check("oob_pslverr", 32'(err), 32'h1);
    apb_read(8'h01, rd, err);
    check("lowbits_load0", rd, PERIOD);
    check("ok_pslverr", 32'(err), 32'h0);
    apb_write(8'h50, 32'h77);
    apb_write(8'h54, 32'h0);
    apb_read(8'h10, rd, err); check("oob_no_load1", rd, 32'h0);
    apb_read(8'h14, rd, err); check("oob_no_ctrl1", rd, 32'h3);

    // Reset in the middle of active counting.
    apb_write(8'h20, 32'd3);
    apb_write(8'h24, 32'h7);
    repeat (5) tick();
    check("pre_rst_fabint", 32'(fabint), 32'h1);
    nreset = 1'b0;
    tick();
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_fabint", 32'(fabint), 32'h0);
    peek_chk("mid_rst_pend2", 8'h2C, 32'h0);
    peek_chk("mid_rst_load2", 8'h20, PERIOD);
    peek_chk("mid_rst_ctrl2", 8'h24, 32'h0);
    peek_chk("mid_rst_ctrl0", 8'h04, 32'h7);
    psel = 1'b0; penable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
